// File: rtl/jh_pkg.sv
// Shared constants, state encoding and tail-block helper for the JH message padder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Ports: none. Provides block/state/length-field widths, the JH pad marker byte,
// the padder FSM state type and a function that assembles the length-carrying
// final block.
package jh_pkg;

   // JH keeps a 1024-bit chaining state; each compression absorbs half of it.
   localparam int STATE_W     = 1024;
   localparam int BLOCK_W     = STATE_W / 2;
   localparam int LEN_FIELD_W = 128;
   localparam int WORD_W      = 64;

   // First pad byte: the single 1 bit followed by seven zero bits.
   localparam logic [7:0] PAD_BYTE = 8'h80;

   typedef enum logic [1:0] {
      FILL = 2'd0,   // collecting message words into the block buffer
      OUT  = 2'd1,   // presenting a data block
      TAIL = 2'd2    // presenting the final, length-carrying block
   } jh_state_e;

   // Final block layout: lead byte, zero fill, 128-bit big-endian bit length.
   function automatic logic [BLOCK_W-1:0] tail_block(
      input logic [7:0]             lead_byte,
      input logic [LEN_FIELD_W-1:0] bit_len
   );
      tail_block = {lead_byte, {(BLOCK_W-8-LEN_FIELD_W){1'b0}}, bit_len};
   endfunction

endpackage

// File: rtl/jh_last_word_pad.sv
// Masks the final message word to its valid bytes and locates the pad marker.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   in_data     - final message word, byte 0 in [63:56]
//   in_bytes    - valid byte count (values above 8 are treated as 8)
//   masked_word - in_data with bytes at and beyond the count forced to zero
//   pad_ins     - the 0x80 marker lands inside this word (count < 8)
//   pad_pos     - byte position of the marker within the word when pad_ins
//   byte_cnt    - clamped valid byte count, 0..8
module jh_last_word_pad
   import jh_pkg::*;
(
   input  logic [WORD_W-1:0] in_data,
   input  logic [3:0]        in_bytes,
   output logic [WORD_W-1:0] masked_word,
   output logic              pad_ins,
   output logic [2:0]        pad_pos,
   output logic [3:0]        byte_cnt
);

   always_comb begin
      byte_cnt = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
   end

   // Keep bytes 0..byte_cnt-1 (MSB-first), clear the rest.
   always_comb begin
      masked_word = '0;
      for (int i = 0; i < 8; i++) begin
         if (4'(i) < byte_cnt) begin
            masked_word[WORD_W-1-8*i -: 8] = in_data[WORD_W-1-8*i -: 8];
         end
      end
   end

   // A full word pushes the marker into the following word (or the lead byte).
   always_comb begin
      pad_ins = (byte_cnt < 4'd8);
      pad_pos = byte_cnt[2:0];
   end

endmodule

// File: rtl/jh_msg_pad.sv
// JH message padder: packs 64-bit big-endian words into 512-bit blocks and appends JH padding.
// Latency: blk_valid rises one cycle after the edge that accepts the 8th or the last word.
// Backpressure: blk_data/blk_last hold while blk_valid & !blk_ready; in_ready is low whenever a block is pending.
//
// Ports:
//   clk, rst                         - clock, asynchronous active-high reset
//   in_valid/in_ready/in_data        - message word stream, byte 0 in in_data[63:56]
//   in_last/in_bytes                 - end-of-message flag and valid byte count of that word
//   blk_valid/blk_ready/blk_data     - padded 512-bit block stream, word k at [511-64k -: 64]
//   blk_last                         - block carries the message length (final block)
module jh_msg_pad
   import jh_pkg::*;
#(
   parameter int LEN_W = 64
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WORD_W-1:0]  in_data,
   input  logic               in_last,
   input  logic [3:0]         in_bytes,
   output logic               blk_valid,
   input  logic               blk_ready,
   output logic [BLOCK_W-1:0] blk_data,
   output logic               blk_last
);

   jh_state_e         state;
   logic [2:0]        widx;       // next buffer word to fill
   logic [LEN_W-1:0]  len_cnt;    // message length in bits, wraps silently
   logic              tail_pend;  // a length block must follow the current data block
   logic [7:0]        lead;       // first byte of the tail block

   logic [WORD_W-1:0] masked_word;
   logic              pad_ins;
   logic [2:0]        pad_pos;
   logic [3:0]        byte_cnt;

   logic [WORD_W-1:0]  word_pad;
   logic [BLOCK_W-1:0] buf_word;   // buffer with a full word written at widx
   logic [BLOCK_W-1:0] buf_last;   // buffer with the padded last word written at widx
   logic [LEN_W-1:0]   len_word;
   logic [LEN_W-1:0]   len_last;
   logic [7:0]         lead_last;
   logic               in_acc;
   logic               blk_acc;
   logic               empty_end;

   jh_last_word_pad u_last_word_pad (
      .in_data     (in_data),
      .in_bytes    (in_bytes),
      .masked_word (masked_word),
      .pad_ins     (pad_ins),
      .pad_pos     (pad_pos),
      .byte_cnt    (byte_cnt)
   );

   always_comb begin
      in_acc  = in_valid & in_ready;
      blk_acc = blk_valid & blk_ready;
   end

   // Pad offset 8*widx + b is zero only at a block boundary with no trailing
   // bytes; then the buffer holds nothing and the tail block is sent alone.
   always_comb begin
      empty_end = (widx == 3'd0) && (byte_cnt == 4'd0);
   end

   always_comb begin
      word_pad = masked_word;
      for (int i = 0; i < 8; i++) begin
         if (pad_ins && (pad_pos == 3'(i))) begin
            word_pad[WORD_W-1-8*i -: 8] = PAD_BYTE;
         end
      end
   end

   // Words beyond widx are already zero (buffer is cleared on each new block),
   // so inserting the marker is all the zero-fill the data block needs.
   always_comb begin
      buf_word = blk_data;
      buf_last = blk_data;
      for (int k = 0; k < 8; k++) begin
         if (widx == 3'(k)) begin
            buf_word[BLOCK_W-1-WORD_W*k -: WORD_W] = in_data;
            buf_last[BLOCK_W-1-WORD_W*k -: WORD_W] = word_pad;
         end
         // Full last word: marker opens the next word of the same block.
         if (!pad_ins && (({1'b0, widx} + 4'd1) == 4'(k))) begin
            buf_last[BLOCK_W-1-WORD_W*k -: 8] = PAD_BYTE;
         end
      end
   end

   always_comb begin
      len_word  = len_cnt + LEN_W'(WORD_W);
      len_last  = len_cnt + LEN_W'({byte_cnt, 3'b000});
      // A full last word in slot 7 fills the block exactly; the marker moves to the tail.
      lead_last = (!pad_ins && (widx == 3'd7)) ? PAD_BYTE : 8'h00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FILL;
         widx      <= 3'd0;
         len_cnt   <= '0;
         tail_pend <= 1'b0;
         lead      <= 8'h00;
         in_ready  <= 1'b0;
         blk_valid <= 1'b0;
         blk_last  <= 1'b0;
         blk_data  <= '0;
      end else begin
         case (state)
            FILL: begin
               in_ready <= 1'b1;
               if (in_acc) begin
                  if (!in_last) begin
                     blk_data <= buf_word;
                     len_cnt  <= len_word;
                     widx     <= widx + 3'd1;
                     if (widx == 3'd7) begin
                        state     <= OUT;
                        in_ready  <= 1'b0;
                        blk_valid <= 1'b1;
                     end
                  end else begin
                     len_cnt   <= len_last;
                     tail_pend <= 1'b1;
                     in_ready  <= 1'b0;
                     blk_valid <= 1'b1;
                     if (empty_end) begin
                        lead     <= PAD_BYTE;
                        blk_data <= tail_block(PAD_BYTE, LEN_FIELD_W'(len_last));
                        blk_last <= 1'b1;
                        state    <= TAIL;
                     end else begin
                        lead     <= lead_last;
                        blk_data <= buf_last;
                        state    <= OUT;
                     end
                  end
               end
            end

            OUT: begin
               if (blk_acc) begin
                  if (tail_pend) begin
                     blk_data <= tail_block(lead, LEN_FIELD_W'(len_cnt));
                     blk_last <= 1'b1;
                     state    <= TAIL;
                  end else begin
                     blk_data  <= '0;
                     blk_valid <= 1'b0;
                     widx      <= 3'd0;
                     in_ready  <= 1'b1;
                     state     <= FILL;
                  end
               end
            end

            TAIL: begin
               if (blk_acc) begin
                  len_cnt   <= '0;
                  widx      <= 3'd0;
                  tail_pend <= 1'b0;
                  lead      <= 8'h00;
                  blk_data  <= '0;
                  blk_valid <= 1'b0;
                  blk_last  <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= FILL;
               end
            end

            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jh_msg_pad.sv
module tb_jh_msg_pad;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [63:0]  in_data = '0;
   logic         in_last = 1'b0;
   logic [3:0]   in_bytes = '0;
   logic         blk_valid;
   logic         blk_ready = 1'b1;
   logic [511:0] blk_data;
   logic         blk_last;

   int checks = 0;
   int errors = 0;

   logic [512:0] obq[$];   // {blk_last, blk_data} of each transferred block

   typedef struct {
      logic [63:0]  dat;
      logic [3:0]   nb;
      int           nblk;
      logic [511:0] b0;
      logic [511:0] b1;
   } vec_t;

   vec_t vecs[6];

   jh_msg_pad #(.LEN_W(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_bytes  (in_bytes),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_last  (blk_last)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst && blk_valid && blk_ready) obq.push_back({blk_last, blk_data});
   end

   always @(posedge clk) begin
      if (in_valid && in_ready && in_last)
         assert (in_bytes <= 4'd8) else $error("illegal in_bytes %0d", in_bytes);
   end

   task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, got, exp);
      end
   endtask

   // Called and returns at posedge+1.
   task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] nb);
      int n;
      n = 0;
      in_valid = 1'b1; in_data = d; in_last = l; in_bytes = nb;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         n++;
         @(negedge clk);
      end
      chk32("in_ready_wait", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; in_bytes = '0;
   endtask

   task automatic wait_blocks(input int n);
      int t;
      t = 0;
      while (obq.size() < n && t < 400) begin
         t++;
         @(negedge clk);
      end
      repeat (4) @(negedge clk);
      chk32("blk_count", 32'(obq.size()), 32'(n));
      @(posedge clk); #1;
   endtask

   task automatic chk_blk(input string name, input int idx, input logic [511:0] exp, input logic exp_last);
      logic [512:0] e;
      if (idx < obq.size()) begin
         e = obq[idx];
         chk({name, "_data"}, e[511:0], exp);
         chk32({name, "_last"}, 32'(e[512]), 32'(exp_last));
      end else begin
         chk32({name, "_present"}, 32'(obq.size()), 32'(idx + 1));
      end
   endtask

   logic [63:0]  w[8];
   logic [511:0] exp_b;
   logic [511:0] abc_b0;
   logic [511:0] abc_b1;

   initial begin
      // Single-word messages: data, byte count, blocks expected, first block, tail block.
      vecs[0] = '{64'h1122334455667788, 4'd0, 1, {8'h80, 504'h0}, 512'h0};
      vecs[1] = '{64'hABCDEF0123456789, 4'd1, 2, {64'hAB80000000000000, 448'h0},
                  {8'h00, 376'h0, 128'h8}};
      vecs[2] = '{64'h6162630000000000, 4'd3, 2, {64'h6162638000000000, 448'h0},
                  {8'h00, 376'h0, 128'h18}};
      vecs[3] = '{64'h616263FFFFFFFFFF, 4'd3, 2, {64'h6162638000000000, 448'h0},
                  {8'h00, 376'h0, 128'h18}};
      vecs[4] = '{64'h0102030405060708, 4'd7, 2, {64'h0102030405060780, 448'h0},
                  {8'h00, 376'h0, 128'h38}};
      vecs[5] = '{64'hDEADBEEFCAFEF00D, 4'd8, 2,
                  {64'hDEADBEEFCAFEF00D, 64'h8000000000000000, 384'h0},
                  {8'h00, 376'h0, 128'h40}};
      abc_b0 = {64'h6162638000000000, 448'h0};
      abc_b1 = {8'h00, 376'h0, 128'h18};
      for (int k = 0; k < 8; k++) w[k] = 64'h0001020304050607 + 64'h0808080808080808 * 64'(k);

      // Reset state
      repeat (2) @(negedge clk);
      chk32("rst_in_ready", 32'(in_ready), 32'd0);
      chk32("rst_blk_valid", 32'(blk_valid), 32'd0);
      chk32("rst_blk_last", 32'(blk_last), 32'd0);
      chk("rst_blk_data", blk_data, 512'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk32("rdy_before_edge", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk32("rdy_after_edge", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      // Table-driven single-word messages
      for (int v = 0; v < 6; v++) begin
         obq.delete();
         send_word(vecs[v].dat, 1'b1, vecs[v].nb);
         wait_blocks(vecs[v].nblk);
         chk_blk($sformatf("vec%0d_b0", v), 0, vecs[v].b0, vecs[v].nblk == 1);
         if (vecs[v].nblk == 2) chk_blk($sformatf("vec%0d_b1", v), 1, vecs[v].b1, 1'b1);
      end

      // 64-byte message: data block unchanged, tail carries the marker and 0x200
      obq.delete();
      for (int k = 0; k < 8; k++) send_word(w[k], k == 7, 4'd8);
      wait_blocks(2);
      exp_b = '0;
      for (int k = 0; k < 8; k++) exp_b[511-64*k -: 64] = w[k];
      chk_blk("m64_b0", 0, exp_b, 1'b0);
      chk_blk("m64_b1", 1, {8'h80, 376'h0, 128'h200}, 1'b1);

      // 60-byte message: marker at byte 60, tail length 0x1E0
      obq.delete();
      for (int k = 0; k < 8; k++) send_word(w[k], k == 7, (k == 7) ? 4'd4 : 4'd8);
      wait_blocks(2);
      exp_b[63:0] = 64'h38393A3B80000000;
      chk_blk("m60_b0", 0, exp_b, 1'b0);
      chk_blk("m60_b1", 1, {8'h00, 376'h0, 128'h1E0}, 1'b1);

      // Boundary-aligned end: 8 full words then an empty last word
      obq.delete();
      for (int k = 0; k < 8; k++) send_word(w[k], 1'b0, 4'd0);
      send_word(64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd0);
      wait_blocks(2);
      for (int k = 0; k < 8; k++) exp_b[511-64*k -: 64] = w[k];
      chk_blk("m64e_b0", 0, exp_b, 1'b0);
      chk_blk("m64e_b1", 1, {8'h80, 376'h0, 128'h200}, 1'b1);

      // Backpressure in OUT and TAIL
      obq.delete();
      blk_ready = 1'b0;
      send_word(64'h6162630000000000, 1'b1, 4'd3);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk32("bp_out_valid", 32'(blk_valid), 32'd1);
         chk32("bp_out_in_ready", 32'(in_ready), 32'd0);
         chk32("bp_out_last", 32'(blk_last), 32'd0);
         chk("bp_out_data", blk_data, abc_b0);
      end
      @(posedge clk); #1;
      blk_ready = 1'b1;
      @(posedge clk); #1;
      blk_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk32("bp_tail_valid", 32'(blk_valid), 32'd1);
         chk32("bp_tail_in_ready", 32'(in_ready), 32'd0);
         chk32("bp_tail_last", 32'(blk_last), 32'd1);
         chk("bp_tail_data", blk_data, abc_b1);
      end
      @(posedge clk); #1;
      blk_ready = 1'b1;
      wait_blocks(2);
      chk_blk("bp_b0", 0, abc_b0, 1'b0);
      chk_blk("bp_b1", 1, abc_b1, 1'b1);

      // Reset mid-message, then "abc" must come out exactly as from a clean start
      obq.delete();
      for (int k = 0; k < 3; k++) send_word(w[k], 1'b0, 4'd8);
      rst = 1'b1;
      @(negedge clk);
      chk32("mrst_in_ready", 32'(in_ready), 32'd0);
      chk32("mrst_blk_valid", 32'(blk_valid), 32'd0);
      chk("mrst_blk_data", blk_data, 512'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      send_word(64'h6162630000000000, 1'b1, 4'd3);
      wait_blocks(2);
      chk_blk("mrst_b0", 0, abc_b0, 1'b0);
      chk_blk("mrst_b1", 1, abc_b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
